// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator.
//   state_e     : controller state encoding
//   chunk_count : number of CHUNK-wide slices in a DATA_WIDTH word
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic int unsigned chunk_count(input int unsigned data_width,
                                                input int unsigned chunk);
        return data_width / chunk;
    endfunction

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors: reduces three operands to a sum and a carry word.
//   a_i, b_i, c_i : operands
//   sum_o         : bitwise sum (a ^ b ^ c)
//   carry_o       : majority(a, b, c) shifted left by one; the MSB carry is dropped
module csa_row #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] c_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic [DATA_WIDTH-1:0] carry_o
);

    assign sum_o = a_i ^ b_i ^ c_i;

    // Only the lower DATA_WIDTH-1 majority bits survive the shift.
    assign carry_o = {(a_i[DATA_WIDTH-2:0] & b_i[DATA_WIDTH-2:0]) |
                      (a_i[DATA_WIDTH-2:0] & c_i[DATA_WIDTH-2:0]) |
                      (b_i[DATA_WIDTH-2:0] & c_i[DATA_WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save accumulator: operands are folded into a sum/carry pair with one
// 3:2 row per accepted operand, then the pair is resolved CHUNK bits per cycle
// with a rippling chunk carry.
//   clk, clr_n           : clock, synchronous active-low clear
//   in_valid/in_ready    : operand handshake; in_last marks the final operand
//   in_data              : operand
//   out_valid/out_ready  : result handshake
//   out_data, out_count  : sum modulo 2^DATA_WIDTH and saturating operand count
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned CHUNK       = 16,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] out_count
);

    localparam int unsigned NCHUNK = chunk_count(DATA_WIDTH, CHUNK);
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((DATA_WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("csa_accumulator: DATA_WIDTH must be a multiple of CHUNK");
    end

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  sum_q, sum_d;
    logic [DATA_WIDTH-1:0]  carry_q, carry_d;
    logic [DATA_WIDTH-1:0]  res_q, res_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   cin_q, cin_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                   in_ready_q, out_valid_q;

    logic [DATA_WIDTH-1:0]  row_sum, row_carry;
    logic [CHUNK-1:0]       sum_chunk, carry_chunk;
    logic [CHUNK:0]         chunk_add;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   accept;

    csa_row #(.DATA_WIDTH(DATA_WIDTH)) u_row (
        .a_i     (sum_q),
        .b_i     (carry_q),
        .c_i     (in_data),
        .sum_o   (row_sum),
        .carry_o (row_carry)
    );

    assign accept    = in_valid && in_ready_q;
    assign count_inc = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);

    // Current resolve slice; carry-out lands in chunk_add[CHUNK].
    assign sum_chunk   = sum_q[32'(idx_q) * CHUNK +: CHUNK];
    assign carry_chunk = carry_q[32'(idx_q) * CHUNK +: CHUNK];
    assign chunk_add   = {1'b0, sum_chunk} + {1'b0, carry_chunk} + {{CHUNK{1'b0}}, cin_q};

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        res_d       = res_q;
        count_d     = count_q;
        idx_d       = idx_q;
        cin_d       = cin_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sum_d   = in_data;
                    carry_d = '0;
                    count_d = COUNT_WIDTH'(1);
                    idx_d   = '0;
                    cin_d   = 1'b0;
                    state_d = in_last ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    sum_d   = row_sum;
                    carry_d = row_carry;
                    count_d = count_inc;
                    idx_d   = '0;
                    cin_d   = 1'b0;
                    state_d = in_last ? RESOLVE : ACCUM;
                end
            end
            RESOLVE: begin
                res_d[32'(idx_q) * CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
                cin_d = chunk_add[CHUNK];
                idx_d = idx_q + IDX_W'(1);
                // Top chunk carry-out is dropped: result wraps.
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    state_d     = DONE;
                    out_data_d  = res_d;
                    out_count_d = count_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; handshake flags decoded from next state.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            carry_q     <= '0;
            res_q       <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            cin_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            res_q       <= res_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            cin_q       <= cin_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            in_ready_q  <= (state_d == IDLE) || (state_d == ACCUM);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator (DATA_WIDTH=64, CHUNK=16, COUNT_WIDTH=8).
module tb_csa_accumulator;

    localparam int unsigned DW  = 64;
    localparam int unsigned CH  = 16;
    localparam int unsigned CW  = 8;
    localparam int          LAT = DW / CH;
    localparam int          CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] count;
    } exp_t;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] ops[$];
    logic [DW-1:0] m_sum;
    int            m_cnt;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    csa_accumulator #(.DATA_WIDTH(DW), .CHUNK(CH), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on every completed output handshake.
    always @(negedge clk) begin
        if (clr_n && out_valid && out_ready) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_count", 64'(out_count), 64'(mon_e.count));
            end
        end
    end

    // Drive one operand until accepted; update the reference model on accept.
    task automatic send_op(input logic [DW-1:0] d, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (m_cnt == 0) m_sum = d;
        else            m_sum = m_sum + d;
        m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        if (last) begin
            exp_q.push_back(exp_t'{data: m_sum, count: CW'(m_cnt)});
            m_cnt = 0;
        end
    endtask

    // Count edges from the last-accept edge until out_valid rises (bounded).
    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 50);
        check({tag, "_latency"}, 64'(n), 64'(LAT));
    endtask

    task automatic send_set(input string tag);
        foreach (ops[i]) send_op(ops[i], i == ops.size() - 1);
        wait_done(tag);
    endtask

    initial begin
        clr_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        m_sum     = '0;
        m_cnt     = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        clr_n = 1'b1;

        // 1 + 2 + 3, then output holds after returning to IDLE.
        ops = {64'd1, 64'd2, 64'd3};
        send_set("sum123");
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("hold_out_data", out_data, 64'd6);
        check("hold_out_count", 64'(out_count), 64'd3);

        // Wrap modulo 2^64.
        ops = {64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        send_set("wrap");
        @(posedge clk);
        #1;

        // Single operand set.
        ops = {64'h1234};
        send_set("single");
        @(posedge clk);
        #1;

        // Back-pressure in DONE: result stable, input pulses ignored.
        out_ready = 1'b0;
        ops = {64'd5, 64'd10};
        send_set("stall");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_last  = 1'b1;
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_data", out_data, 64'd15);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_ready", 64'(in_ready), 64'd1);

        // Clear during the second resolve cycle abandons the set.
        send_op(64'd100, 1'b0);
        send_op(64'd200, 1'b1);
        @(posedge clk);
        #1;
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        exp_q.delete();
        m_cnt = 0;
        check("clr_in_ready", 64'(in_ready), 64'd1);
        check("clr_out_valid", 64'(out_valid), 64'd0);
        check("clr_out_data", out_data, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("clr_no_result", 64'(out_valid), 64'd0);
        ops = {64'd7, 64'd8};
        send_set("after_clr");
        @(posedge clk);
        #1;

        // 300 ones: count saturates, sum does not.
        for (int i = 0; i < 300; i++) send_op(64'd1, i == 299);
        wait_done("sat");
        @(posedge clk);
        #1;
        check("sat_out_data", out_data, 64'd300);
        check("sat_out_count", 64'(out_count), 64'd255);

        // A few random sets.
        for (int s = 0; s < 4; s++) begin
            ops.delete();
            for (int k = 0; k < int'($urandom_range(1, 6)); k++)
                ops.push_back({$urandom, $urandom});
            send_set("random");
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
